// File: rtl/nor_chk_pkg.sv
// ============================================================================
// Module      : nor_chk_pkg
// Description : Shared FSM encoding and vector width for the gate checkers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nor_chk_pkg;

    localparam int c_VEC_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/nor3_ref.sv
// ============================================================================
// Module      : nor3_ref
// Description : Golden 3-input NOR used as the expected-value reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nor3_ref (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_y
);

    assign o_y = ~(i_a | i_b | i_c);

endmodule

`default_nettype wire

// File: rtl/nor3_resp_checker.sv
// ============================================================================
// Module      : nor3_resp_checker
// Description : Checks observed NOR3 responses against a reference, tracking
//               counts, input coverage, first failure and an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nor3_resp_checker
    import nor_chk_pkg::*;
#(
    parameter int NUM_VEC     = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_a,
    input  logic               in_b,
    input  logic               in_c,
    input  logic               in_y,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [7:0]         vec_cnt,
    output logic [7:0]         err_cnt,
    output logic [7:0]         cov_map,
    output logic [c_VEC_W-1:0] first_err_vec,
    output logic               first_err_vld
);

    localparam logic [7:0] c_NUM_VEC = 8'(NUM_VEC);
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYC);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_vec_cnt;
    logic [7:0]         r_err_cnt;
    logic [7:0]         r_cov_map;
    logic [7:0]         r_tmr;
    logic [c_VEC_W-1:0] r_fe_vec;
    logic               r_fe_vld;

    logic [c_VEC_W-1:0] w_vec;
    logic               w_exp_y;
    logic               w_accept;
    logic               w_mismatch;
    logic               w_last_vec;
    logic               w_tmr_exp;
    logic               w_clear;
    logic               w_cov_ok;

    nor3_ref u_ref (
        .i_a (in_a),
        .i_b (in_b),
        .i_c (in_c),
        .o_y (w_exp_y)
    );

    assign w_vec      = {in_a, in_b, in_c};
    assign w_accept   = in_valid && (r_state == ST_RUN);
    assign w_mismatch = (in_y != w_exp_y);
    assign w_last_vec = ((r_vec_cnt + 8'd1) == c_NUM_VEC);
    assign w_tmr_exp  = ((r_tmr + 8'd1) == c_TIMEOUT);
    assign w_clear    = start && (r_state != ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Acceptance is tested first so it wins over a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    if (w_last_vec) begin
                        w_state_nxt = ST_DONE;
                    end
                end else if (w_tmr_exp) begin
                    w_state_nxt = ST_TMO;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_cnt <= 8'h00;
            r_err_cnt <= 8'h00;
            r_cov_map <= 8'h00;
            r_tmr     <= 8'h00;
            r_fe_vec  <= '0;
            r_fe_vld  <= 1'b0;
        end else if (w_clear) begin
            r_vec_cnt <= 8'h00;
            r_err_cnt <= 8'h00;
            r_cov_map <= 8'h00;
            r_tmr     <= 8'h00;
            r_fe_vec  <= '0;
            r_fe_vld  <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (w_accept) begin
                r_tmr     <= 8'h00;
                r_vec_cnt <= r_vec_cnt + 8'd1;
                r_cov_map <= r_cov_map | (8'd1 << w_vec);
                if (w_mismatch) begin
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    if (!r_fe_vld) begin
                        r_fe_vec <= w_vec;
                        r_fe_vld <= 1'b1;
                    end
                end
            end else begin
                r_tmr <= r_tmr + 8'd1;
            end
        end
    end

    // Full coverage is only demanded when a run is long enough to reach it.
    assign w_cov_ok = (NUM_VEC < 8) || (r_cov_map == 8'hFF);

    assign in_ready      = (r_state == ST_RUN);
    assign busy          = (r_state == ST_RUN);
    assign done          = (r_state == ST_DONE) || (r_state == ST_TMO);
    assign timeout       = (r_state == ST_TMO);
    assign pass          = (r_state == ST_DONE) && (r_err_cnt == 8'h00) && w_cov_ok;
    assign vec_cnt       = r_vec_cnt;
    assign err_cnt       = r_err_cnt;
    assign cov_map       = r_cov_map;
    assign first_err_vec = r_fe_vec;
    assign first_err_vld = r_fe_vld;

endmodule

`default_nettype wire
